// File: rtl/seq_divider_unit.sv
// seq_divider_unit: multi-cycle restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands; unsigned otherwise.
module seq_divider_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r, quo_r, den_r;
    logic             sign_q, sign_r;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] s_r, s_q, s_d, nxt_r, nxt_q;
    logic [WIDTH:0]   shifted, diff;
`ifdef DIV_SIGNED_EN
    assign neg_a = dividend[WIDTH-1];
    assign neg_b = divisor[WIDTH-1];
`else
    assign neg_a = 1'b0;
    assign neg_b = 1'b0;
`endif
    assign abs_a = neg_a ? -dividend : dividend;
    assign abs_b = neg_b ? -divisor : divisor;
    // The accepting edge already resolves the top quotient bit, so CALC needs WIDTH-1 more.
    always_comb begin
        s_r     = (state == IDLE) ? '0 : rem_r;
        s_q     = (state == IDLE) ? abs_a : quo_r;
        s_d     = (state == IDLE) ? abs_b : den_r;
        shifted = {s_r, s_q[WIDTH-1]};
        diff    = shifted - {1'b0, s_d};
        nxt_r   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        nxt_q   = {s_q[WIDTH-2:0], ~diff[WIDTH]};
    end
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            den_r       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy   <= 1'b1;
                    den_r  <= abs_b;
                    sign_q <= neg_a ^ neg_b;
                    sign_r <= neg_a;
                    if (divisor == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        rem_r       <= nxt_r;
                        quo_r       <= nxt_q;
                        cnt         <= CW'(WIDTH - 1);
                        state       <= CALC;
                    end
                end
                CALC: begin
                    rem_r <= nxt_r;
                    quo_r <= nxt_q;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    quotient  <= sign_q ? -quo_r : quo_r;
                    remainder <= sign_r ? -rem_r : rem_r;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider_unit.sv
// tb_seq_divider_unit: randomized and directed checks of seq_divider_unit against an arithmetic model.
module tb_seq_divider_unit;
    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    int errors = 0;
    int checks = 0;

    seq_divider_unit #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
`ifdef DIV_SIGNED_EN
        if (b == 0) begin q = '1; r = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = 0; end
        else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
`else
        if (b == 0) begin q = '1; r = a; end
        else begin q = a / b; r = a % b; end
`endif
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit poke);
        int n;
        logic [31:0] eq, er;
        model(a, b, eq, er);
        @(negedge clock);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clock); n = 1; #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        check("busy_after_start", busy, 1);
        while (!done && n < 100) begin
            if (poke && n == 10) begin start = 1'b1; dividend = $urandom; divisor = $urandom_range(1, 9); end
            @(posedge clock); n++; #1;
            start = 1'b0;
        end
        check("latency", n, (b == 0) ? 1 : 33);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
        check("busy_in_done", busy, 1);
        @(posedge clock); #1;
        check("done_pulse_end", done, 0);
        check("busy_end", busy, 0);
        check("quotient_held", quotient, eq);
    endtask

    initial begin
        int seen;
        logic [31:0] a, b;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clock); clear = 1'b1;
`ifdef DIV_SIGNED_EN
        do_div(32'd30, 32'd25, 0);
        do_div(32'hFFFF_FFF9, 32'd2, 0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_div(32'h8000_0000, 32'd1, 0);
        do_div(32'd7, 32'hFFFF_FFFE, 0);
`else
        do_div(32'hFFFF_FFF9, 32'd2, 0);
        do_div(32'd30, 32'd25, 0);
`endif
        do_div(32'd123, 32'd0, 0);
        do_div(32'd1000, 32'd3, 1);
        do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_div(32'd5, 32'd9, 0);
        // Abort mid-division: an ignored second start, then clear at edge 20.
        @(negedge clock);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock); start = 1'b1; dividend = 32'd5; divisor = 32'd1;
        @(posedge clock); #1; start = 1'b0;
        check("second_start_ignored_busy", busy, 1);
        repeat (9) @(posedge clock);
        @(negedge clock); clear = 1'b0; #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (i == 3) clear = 1'b1;
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_idle_busy", busy, 0);
        do_div(32'd100, 32'd7, 0);
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom_range(1, 15);
                1: b = $urandom;
                2: b = (i == 6) ? 32'd0 : {16'd0, 16'($urandom)};
                default: b = -32'($urandom_range(1, 300));
            endcase
            do_div(a, b, (i % 5) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
